ram4_bank: RTL and testbench
============================

Name: ram4_bank

Overview:
4-word x WIDTH-bit register bank that sits directly downstream of the 4-way load demultiplexer. The 2-bit address routes load_i to exactly one word's write enable, decoded as a==00, b==01, c==10, d==11. The read path selects the addressed word combinationally, Hack-RAM style.
The bank adds a sequenced clear engine: on request it zeroes all four words, one word per cycle, and reports busy and done. It is the building block for the RAM8/RAM64 hierarchy wherever bulk clear is needed.

Parameters:
WIDTH, 16, data word width in bits (>=1)

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  reset, synchronous, active-high
in_i  input  WIDTH  write data
load_i  input  1  write request for word address_i
address_i  input  2  word select for write and read
clear_i  input  1  request zeroing of all four words
out_o  output  WIDTH  contents of word address_i
busy_o  output  1  clear sweep in progress
clear_done_o  output  1  one-cycle pulse after the sweep completes

Behaviour:
- Reset (rst_i=1 at an edge):
  - All four words, state, sweep pointer, busy_o and clear_done_o go to 0.
  - Reset overrides any load_i or clear_i in the same cycle, including mid-sweep.
- Storage: word[k] WIDTH bits, k=0..3.
- Write enable:
  - we[k] = load_i & (address_i==k) & (state==IDLE) & ~clear_i.
  - At most one we[k] is high in any cycle.
- Write latency:
  - The word updates at the edge where we[k]=1.
  - out_o shows the new value from the next cycle on.
- Read:
  - out_o = word[address_i], purely combinational from current state and address_i.
  - Read-during-write returns the old value in that cycle.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clear_i=1. The sweep pointer is loaded with 0.
    - A load_i in that same cycle is dropped (clear has priority).
  - In CLEAR, each cycle:
    - word[ptr] <= 0 and ptr <= ptr+1.
    - load_i and clear_i are ignored; a clear_i during a sweep does not restart or extend it.
  - CLEAR -> IDLE at the edge where ptr==3 is written (ptr wraps to 0).
- busy_o:
  - Registered: 1 exactly while state==CLEAR.
  - Request accepted at edge E -> busy_o high for the 4 cycles following E, low again after edge E+4.
- clear_done_o:
  - Registered: 1 for exactly the one cycle following the CLEAR->IDLE edge, otherwise 0.
  - It may coincide with a new clear_i being accepted; that request starts a new sweep normally.
- Sweep visibility: out_o reflects partially cleared contents during the sweep (word k reads 0 from the cycle after its sweep slot).
- Width: no arithmetic on data. ptr is 2 bits and wraps 3->0.

Test Plan:
- Reset then read all addresses -> out_o=0x0000 for address 0..3; busy_o=0, clear_done_o=0.
- Write 0x1111, 0x2222, 0x3333, 0x4444 to addresses 0..3 (load_i=1, one per cycle), then read 0..3 -> 0x1111..0x4444. Only the addressed word changes per write.
- Read-during-write: address 2 holds 0x3333, drive in_i=0xBEEF with load_i=1 -> out_o=0x3333 that cycle, 0xBEEF the next.
- Clear with simultaneous load:
  - Preload 0xAAAA in all words; pulse clear_i with load_i=1, address 1, in_i=0x5555.
  - busy_o=1 for exactly 4 cycles; clear_done_o=1 for exactly 1 cycle after.
  - All words read 0; the 0x5555 write is absent.
- Load and re-clear during sweep: holding load_i=1 and clear_i=1 throughout the sweep -> no word written, sweep still exactly 4 cycles. After it ends, clear_i is re-accepted only in IDLE, and the second sweep starts cleanly.
- Reset mid-sweep: assert rst_i in the 2nd busy cycle -> next cycle busy_o=0, clear_done_o=0, all words 0. A later write of 0x0F0F to address 3 reads back 0x0F0F.

Source files
------------

// File: rtl/ram4_bank.sv
// ram4_bank: 4-word x WIDTH-bit register bank with a sequenced clear engine.
//
// Writes go to word[address_i] when load_i is high, the bank is idle and no
// clear is being requested. Reads are combinational: out_o = word[address_i].
// A clear_i pulse in IDLE starts a sweep that zeroes one word per cycle
// (word 0 first). busy_o is high while the sweep runs. clear_done_o pulses
// for one cycle after the last word has been cleared.
//
// Ports:
//   clk_i        clock; all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   in_i         write data
//   load_i       write request for word address_i
//   address_i    word select for both write and read
//   clear_i      request zeroing of all four words
//   out_o        contents of word address_i
//   busy_o       clear sweep in progress
//   clear_done_o one-cycle pulse after the sweep completes
module ram4_bank #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] in_i,
  input  logic             load_i,
  input  logic [1:0]       address_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] out_o,
  output logic             busy_o,
  output logic             clear_done_o
);

  localparam int NUM_WORDS = 4;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] word_q [NUM_WORDS];
  logic [NUM_WORDS-1:0] we;
  logic [NUM_WORDS-1:0] wipe;

  // Clear has priority over a same-cycle load, and loads are ignored
  // for the whole sweep.
  always_comb begin
    for (int k = 0; k < NUM_WORDS; k++) begin
      we[k]   = load_i && (address_i == 2'(k)) && (state_q == IDLE) && !clear_i;
      wipe[k] = (state_q == CLEAR) && (ptr_q == 2'(k));
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d = CLEAR;
          ptr_d   = 2'd0;
        end
      end
      CLEAR: begin
        // clear_i is ignored here, so a sweep is never restarted or stretched.
        ptr_d = ptr_q + 2'd1;
        if (ptr_q == 2'd3) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      done_q  <= 1'b0;
      for (int k = 0; k < NUM_WORDS; k++) word_q[k] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (wipe[k])    word_q[k] <= '0;
        else if (we[k]) word_q[k] <= in_i;
      end
    end
  end

  // Read path sees the pre-edge value, so read-during-write returns old data.
  assign out_o        = word_q[address_i];
  assign busy_o       = (state_q == CLEAR);
  assign clear_done_o = done_q;

endmodule

// File: tb/tb_ram4_bank.sv
module tb_ram4_bank;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_d;
  logic         load;
  logic [1:0]   addr;
  logic         clr;
  logic [W-1:0] out;
  logic         busy;
  logic         done;

  ram4_bank #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .in_i(in_d), .load_i(load), .address_i(addr),
    .clear_i(clr), .out_o(out), .busy_o(busy), .clear_done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic         busy;
    logic         done;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: memory array plus "how many words the sweep has
  // already cleared" (-1 when no sweep is running).
  logic [W-1:0] mem [4];
  int           swept;
  bit           done_m;

  // Monitor: compares the DUT against the queued expectation on each negedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (out === e.out) n_pass++;
      else $display("FAIL %s out_o: got %h want %h", e.tag, out, e.out);
      n_checks++;
      if (busy === e.busy) n_pass++;
      else $display("FAIL %s busy_o: got %b want %b", e.tag, busy, e.busy);
      n_checks++;
      if (done === e.done) n_pass++;
      else $display("FAIL %s clear_done_o: got %b want %b", e.tag, done, e.done);
    end
  end

  // Drive one cycle's inputs, queue what the outputs must be during that
  // cycle, then advance the model across the clock edge.
  task automatic step(input logic r, input logic [W-1:0] d, input logic ld,
                      input logic [1:0] a, input logic c, input string tag);
    exp_t e;
    rst = r; in_d = d; load = ld; addr = a; clr = c;
    e.out  = mem[a];
    e.busy = (swept >= 0);
    e.done = done_m;
    e.tag  = tag;
    exp_q.push_back(e);
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 4; k++) mem[k] = '0;
      swept  = -1;
      done_m = 0;
    end else if (swept >= 0) begin
      mem[swept] = '0;
      done_m = (swept == 3);
      swept  = (swept == 3) ? -1 : swept + 1;
    end else begin
      done_m = 0;
      if (c)       swept = 0;
      else if (ld) mem[a] = d;
    end
    #1;
  endtask

  task automatic rd(input logic [1:0] a, input string tag);
    step(0, 16'h0000, 0, a, 0, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 4; k++) mem[k] = '0;
    swept = -1; done_m = 0;
    rst = 1; in_d = '0; load = 0; addr = 0; clr = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset state
    for (int a = 0; a < 4; a++) rd(2'(a), "reset_read");

    // basic writes then readback
    step(0, 16'h1111, 1, 2'd0, 0, "wr0");
    step(0, 16'h2222, 1, 2'd1, 0, "wr1");
    step(0, 16'h3333, 1, 2'd2, 0, "wr2");
    step(0, 16'h4444, 1, 2'd3, 0, "wr3");
    for (int a = 0; a < 4; a++) rd(2'(a), "readback");

    // read-during-write on address 2
    step(0, 16'hBEEF, 1, 2'd2, 0, "rdw_old");
    rd(2'd2, "rdw_new");

    // clear with simultaneous load
    for (int a = 0; a < 4; a++) step(0, 16'hAAAA, 1, 2'(a), 0, "preload");
    step(0, 16'h5555, 1, 2'd1, 1, "clr_load");
    for (int i = 0; i < 5; i++) rd(2'(i), "sweep");
    for (int a = 0; a < 4; a++) rd(2'(a), "post_clear");

    // load and clear held through the sweep
    for (int a = 0; a < 4; a++) step(0, 16'h7777, 1, 2'(a), 0, "preload2");
    step(0, 16'h0000, 0, 2'd0, 1, "clr_start");
    for (int i = 0; i < 4; i++) step(0, 16'h9999, 1, 2'(i), 1, "sweep_hold");
    step(0, 16'h1234, 1, 2'd2, 1, "reaccept");
    for (int i = 0; i < 5; i++) step(0, 16'hFFFF, 1, 2'(i), 0, "sweep2");
    for (int a = 0; a < 4; a++) rd(2'(a), "post_clear2");

    // reset mid-sweep
    for (int a = 0; a < 4; a++) step(0, 16'hC3C3, 1, 2'(a), 0, "preload3");
    step(0, 16'h0000, 0, 2'd0, 1, "clr_start3");
    rd(2'd0, "busy1");
    step(1, 16'h0000, 0, 2'd1, 0, "rst_mid");
    for (int a = 0; a < 4; a++) rd(2'(a), "after_rst");
    step(0, 16'h0F0F, 1, 2'd3, 0, "wr_after_rst");
    rd(2'd3, "rd_after_rst");

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2), W'($urandom), ($urandom_range(0, 1) == 1),
           2'($urandom_range(0, 3)), ($urandom_range(0, 99) < 8), "random");
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
